// File: rtl/conversor_bcd_seq.sv
// conversor_bcd_seq: sequential 8-bit binary to 3-digit BCD converter (double dabble, one step per clock)
module conversor_bcd_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] P,
  output logic       busy,
  output logic       done,
  output logic [3:0] centena,
  output logic [3:0] dezena,
  output logic [3:0] unidade
);
  typedef enum logic {OCIOSO, CONVERTE} estado_t;
  estado_t     estado;
  logic [7:0]  sr;
  logic [11:0] acc;
  logic [11:0] accc;
  logic [3:0]  cnt;
  logic [19:0] sh;
  always_comb begin
    accc[3:0]   = acc[3:0]   >= 4'd5 ? acc[3:0]   + 4'd3 : acc[3:0];
    accc[7:4]   = acc[7:4]   >= 4'd5 ? acc[7:4]   + 4'd3 : acc[7:4];
    accc[11:8]  = acc[11:8]  >= 4'd5 ? acc[11:8]  + 4'd3 : acc[11:8];
    sh          = {accc, sr} << 1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado  <= OCIOSO;
      sr      <= '0;
      acc     <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      centena <= '0;
      dezena  <= '0;
      unidade <= '0;
    end else begin
      done <= 1'b0;
      if (estado == OCIOSO) begin
        if (start) begin
          sr     <= P;
          acc    <= '0;
          cnt    <= '0;
          busy   <= 1'b1;
          estado <= CONVERTE;
        end
      end else begin
        acc <= sh[19:8];
        sr  <= sh[7:0];
        cnt <= cnt + 4'd1;
        // eighth shift: the corrected, shifted accumulator is the final result
        if (cnt == 4'd7) begin
          centena <= sh[19:16];
          dezena  <= sh[15:12];
          unidade <= sh[11:8];
          done    <= 1'b1;
          busy    <= 1'b0;
          estado  <= OCIOSO;
        end
      end
    end
  end
endmodule

// File: tb/tb_conversor_bcd_seq.sv
// tb_conversor_bcd_seq: scoreboard bench; expected digits queued at start, checked on each done pulse
module tb_conversor_bcd_seq;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] P = '0;
  logic       busy, done;
  logic [3:0] centena, dezena, unidade;
  int tests = 0;
  int fails = 0;
  int done_count = 0;
  logic prev_done = 1'b0;
  logic [11:0] sb[$];

  conversor_bcd_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .P(P),
    .busy(busy), .done(done),
    .centena(centena), .dezena(dezena), .unidade(unidade)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) begin
      done_count++;
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done: got %0d%0d%0d, required no done", centena, dezena, unidade);
      end else begin
        logic [11:0] e;
        e = sb.pop_front();
        if ({centena, dezena, unidade} !== e) begin
          fails++;
          $display("FAIL digits: got %h, required %h", {centena, dezena, unidade}, e);
        end
      end
      tests++;
      if (busy !== 1'b0 || prev_done !== 1'b0) begin
        fails++;
        $display("FAIL done_shape: busy=%b prev_done=%b, required 0 0", busy, prev_done);
      end
    end
    prev_done <= done;
  end

  function automatic logic [11:0] bcd(input int p);
    return {4'(p / 100), 4'((p / 10) % 10), 4'(p % 10)};
  endfunction

  task automatic launch(input logic [7:0] p);
    P = p;
    start = 1'b1;
    sb.push_back(bcd(p));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int n, output int bc);
    n = 0;
    bc = 0;
    while (!done && n < 20) begin
      if (busy) bc++;
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    tests++;
    if ({busy, done, centena, dezena, unidade} !== 14'd0) begin
      fails++;
      $display("FAIL reset_state: got %b, required 0", {busy, done, centena, dezena, unidade});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int n, bc;
    launch(8'd225);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL busy_after_start: got %b, required 1", busy);
    end
    wait_done(n, bc);
    tests++;
    if (n !== 8) begin
      fails++;
      $display("FAIL latency: got %0d, required 8", n);
    end
    tests++;
    if (bc !== 8) begin
      fails++;
      $display("FAIL busy_cycles: got %0d, required 8", bc);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_vectors;
    int n, bc;
    logic [7:0] v[4] = '{8'd0, 8'd255, 8'd9, 8'd10};
    logic [11:0] e[4] = '{12'h000, 12'h255, 12'h009, 12'h010};
    for (int i = 0; i < 4; i++) begin
      P = v[i];
      start = 1'b1;
      sb.push_back(e[i]);
      @(posedge clk); #1;
      start = 1'b0;
      if (i > 0) begin
        tests++;
        if ({centena, dezena, unidade} !== e[i-1]) begin
          fails++;
          $display("FAIL hold_on_start: got %h, required %h", {centena, dezena, unidade}, e[i-1]);
        end
      end
      wait_done(n, bc);
      tests++;
      if (n !== 8) begin
        fails++;
        $display("FAIL vec_latency: P=%0d got %0d, required 8", v[i], n);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ignore;
    int n, bc, dc;
    dc = done_count;
    launch(8'd100);
    repeat (2) @(posedge clk);
    #1;
    P = 8'd37;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    tests++;
    if (done_count - dc !== 1) begin
      fails++;
      $display("FAIL ignore_start: got %0d dones, required 1", done_count - dc);
    end
  endtask

  task automatic test_abort;
    int dc;
    launch(8'd144);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({busy, done, centena, dezena, unidade} !== 14'd0) begin
      fails++;
      $display("FAIL abort_outputs: got %b, required 0", {busy, done, centena, dezena, unidade});
    end
    sb.delete();
    dc = done_count;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    tests++;
    if (done_count !== dc) begin
      fails++;
      $display("FAIL abort_no_done: got %0d dones, required 0", done_count - dc);
    end
    launch(8'd144);
    repeat (10) @(posedge clk);
    #1;
    tests++;
    if (done_count - dc !== 1) begin
      fails++;
      $display("FAIL abort_restart: got %0d dones, required 1", done_count - dc);
    end
  endtask

  task automatic test_back_to_back;
    int n, bc;
    P = 8'd36;
    start = 1'b1;
    sb.push_back(bcd(36));
    @(posedge clk); #1;
    P = 8'd81;
    sb.push_back(bcd(81));
    wait_done(n, bc);
    tests++;
    if (n !== 8) begin
      fails++;
      $display("FAIL b2b_first: got %0d, required 8", n);
    end
    @(posedge clk); #1;
    start = 1'b0;
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL b2b_accept_on_done: busy %b, required 1", busy);
    end
    wait_done(n, bc);
    tests++;
    if (n !== 8) begin
      fails++;
      $display("FAIL b2b_second: got %0d, required 8", n);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_exhaustive;
    int n, bc, dc;
    dc = done_count;
    for (int p = 0; p < 256; p++) begin
      launch(8'(p));
      wait_done(n, bc);
      @(posedge clk); #1;
    end
    tests++;
    if (done_count - dc !== 256) begin
      fails++;
      $display("FAIL exhaustive_count: got %0d, required 256", done_count - dc);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_basic;
    test_vectors;
    test_ignore;
    test_abort;
    test_back_to_back;
    test_exhaustive;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (sb.size() !== 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
